// File: rtl/axi_typedef_pkg.sv
// Shared AXI write-path types for the write arbiter and its sub-blocks.
package axi_typedef_pkg;

    typedef logic [7:0] len_t;
    typedef logic [1:0] resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2
    } wr_state_t;

endpackage

// File: rtl/rr_arb_sel.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arb_sel #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    // Rotating a doubled copy puts the ptr position at bit 0.
    assign dbl = {req, req};
    assign rot = NUM_REQ'(dbl >> ptr);

    always_comb begin
        int sum;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        valid = 1'b0;
        sum   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                sum   = int'(ptr) + i;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                grant = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI write arbiter: round-robin AW grant held through the W burst,
// master index prepended to the downstream ID, B routed back by that index.
module axi_wr_arbiter
    import axi_typedef_pkg::*;
#(
    parameter int NUM_MST        = 2,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    localparam int IDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
    localparam int STRB_W = AXI_DATA_WIDTH / 8,
    localparam int M_ID_W = AXI_ID_WIDTH + IDX_W
) (
    input  logic                                      clk,
    input  logic                                      rst,

    input  logic [NUM_MST-1:0][AXI_ID_WIDTH-1:0]      s_aw_id,
    input  logic [NUM_MST-1:0][AXI_ADDR_WIDTH-1:0]    s_aw_addr,
    input  len_t [NUM_MST-1:0]                        s_aw_len,
    input  logic [NUM_MST-1:0]                        s_aw_valid,
    output logic [NUM_MST-1:0]                        s_aw_ready,

    input  logic [NUM_MST-1:0][AXI_DATA_WIDTH-1:0]    s_w_data,
    input  logic [NUM_MST-1:0][STRB_W-1:0]            s_w_strb,
    input  logic [NUM_MST-1:0]                        s_w_last,
    input  logic [NUM_MST-1:0]                        s_w_valid,
    output logic [NUM_MST-1:0]                        s_w_ready,

    output logic [AXI_ID_WIDTH-1:0]                   s_b_id,
    output resp_t                                     s_b_resp,
    output logic [NUM_MST-1:0]                        s_b_valid,
    input  logic [NUM_MST-1:0]                        s_b_ready,

    output logic [M_ID_W-1:0]                         m_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]                 m_aw_addr,
    output len_t                                      m_aw_len,
    output logic                                      m_aw_valid,
    input  logic                                      m_aw_ready,

    output logic [AXI_DATA_WIDTH-1:0]                 m_w_data,
    output logic [STRB_W-1:0]                         m_w_strb,
    output logic                                      m_w_last,
    output logic                                      m_w_valid,
    input  logic                                      m_w_ready,

    input  logic [M_ID_W-1:0]                         m_b_id,
    input  resp_t                                     m_b_resp,
    input  logic                                      m_b_valid,
    output logic                                      m_b_ready
);

    wr_state_t        state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] sel_grant;
    logic             sel_valid;
    logic [IDX_W-1:0] b_idx;

    rr_arb_sel #(
        .NUM_REQ (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req   (s_aw_valid),
        .ptr   (rr_ptr_q),
        .grant (sel_grant),
        .valid (sel_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Payload muxes follow the registered grant; it cannot move until the W-last handshake.
    assign m_aw_id   = {grant_q, s_aw_id[grant_q]};
    assign m_aw_addr = s_aw_addr[grant_q];
    assign m_aw_len  = s_aw_len[grant_q];
    assign m_w_data  = s_w_data[grant_q];
    assign m_w_strb  = s_w_strb[grant_q];
    assign m_w_last  = s_w_last[grant_q];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        m_aw_valid = 1'b0;
        m_w_valid  = 1'b0;
        s_aw_ready = '0;
        s_w_ready  = '0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_grant;
                    state_d = AW;
                end
            end
            AW: begin
                m_aw_valid          = 1'b1;
                s_aw_ready[grant_q] = m_aw_ready;
                if (m_aw_ready) begin
                    state_d = W;
                end
            end
            W: begin
                m_w_valid          = s_w_valid[grant_q];
                s_w_ready[grant_q] = m_w_ready;
                if (s_w_valid[grant_q] && m_w_ready && s_w_last[grant_q]) begin
                    rr_ptr_d = (grant_q == IDX_W'(NUM_MST - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // B return path is stateless; an out-of-range index is swallowed so the slave never stalls.
    assign b_idx    = m_b_id[AXI_ID_WIDTH +: IDX_W];
    assign s_b_id   = m_b_id[AXI_ID_WIDTH-1:0];
    assign s_b_resp = m_b_resp;

    always_comb begin
        s_b_valid = '0;
        m_b_ready = 1'b0;
        if (!rst) begin
            if (int'(b_idx) < NUM_MST) begin
                s_b_valid[b_idx] = m_b_valid;
                m_b_ready        = s_b_ready[b_idx];
            end else begin
                m_b_ready = 1'b1;
            end
        end
    end

endmodule
